// File: rtl/egg_timer_ctrl_if.sv
// Button, tick and display signals of the egg timer controller.
// The controller takes the slave side; the driving environment takes the master side.
interface egg_timer_ctrl_if;
    logic       tick;
    logic       btn_start;
    logic       btn_min;
    logic       btn_sec;
    logic       btn_clear;
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       running;
    logic       alarm;
    logic       div_reset;

    modport master (
        output tick, btn_start, btn_min, btn_sec, btn_clear,
        input  min_tens, min_ones, sec_tens, sec_ones, running, alarm, div_reset
    );

    modport slave (
        input  tick, btn_start, btn_min, btn_sec, btn_clear,
        output min_tens, min_ones, sec_tens, sec_ones, running, alarm, div_reset
    );
endinterface

// File: rtl/egg_timer_ctrl.sv
// Egg timer control: BCD mm:ss set/countdown with start/pause, clear and a
// timed alarm that returns to idle after ALARM_TICKS divider ticks.
module egg_timer_ctrl #(
    parameter int ALARM_TICKS     = 10,
    parameter int ALARM_CTR_WIDTH = 8
) (
    input  logic            clk,
    input  logic            reset,
    egg_timer_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        ALARM = 2'd3
    } state_t;

    // Time register packs {min_tens, min_ones, sec_tens, sec_ones}.
    state_t                     state_q, state_d;
    logic [15:0]                time_q, time_d;
    logic [ALARM_CTR_WIDTH-1:0] acnt_q, acnt_d;
    logic                       div_reset_q, div_reset_d;

    logic [15:0] time_dec;
    logic        time_zero;

    function automatic logic [15:0] bcd_inc_min(input logic [15:0] t);
        logic [3:0] mt, mo, st, so;
        {mt, mo, st, so} = t;
        if (mo == 4'd9) begin
            mo = 4'd0;
            mt = (mt == 4'd9) ? 4'd0 : mt + 4'd1;
        end else begin
            mo = mo + 4'd1;
        end
        return {mt, mo, st, so};
    endfunction

    function automatic logic [15:0] bcd_inc_sec(input logic [15:0] t);
        logic [3:0] mt, mo, st, so;
        {mt, mo, st, so} = t;
        if (so == 4'd9) begin
            so = 4'd0;
            st = (st == 4'd5) ? 4'd0 : st + 4'd1;
        end else begin
            so = so + 4'd1;
        end
        return {mt, mo, st, so};
    endfunction

    // Seconds borrow from minutes (xx:00 -> xx-1:59); 00:00 stays put.
    function automatic logic [15:0] bcd_dec(input logic [15:0] t);
        logic [3:0] mt, mo, st, so;
        {mt, mo, st, so} = t;
        if (so != 4'd0) begin
            so = so - 4'd1;
        end else if (st != 4'd0) begin
            st = st - 4'd1;
            so = 4'd9;
        end else if ({mt, mo} != 8'd0) begin
            st = 4'd5;
            so = 4'd9;
            if (mo != 4'd0) begin
                mo = mo - 4'd1;
            end else begin
                mt = mt - 4'd1;
                mo = 4'd9;
            end
        end
        return {mt, mo, st, so};
    endfunction

    assign time_dec  = bcd_dec(time_q);
    assign time_zero = (time_q == 16'd0);

    always_comb begin
        state_d     = state_q;
        time_d      = time_q;
        acnt_d      = acnt_q;
        div_reset_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.btn_clear) begin
                    time_d = 16'd0;
                end else if (bus.btn_start) begin
                    if (!time_zero) begin
                        state_d     = RUN;
                        div_reset_d = 1'b1;
                    end
                end else begin
                    if (bus.btn_min && bus.btn_sec) begin
                        time_d = bcd_inc_sec(bcd_inc_min(time_q));
                    end else if (bus.btn_min) begin
                        time_d = bcd_inc_min(time_q);
                    end else if (bus.btn_sec) begin
                        time_d = bcd_inc_sec(time_q);
                    end
                end
            end
            RUN: begin
                if (bus.btn_clear) begin
                    state_d = IDLE;
                    time_d  = 16'd0;
                end else if (bus.btn_start) begin
                    state_d = PAUSE;
                end else if (bus.tick) begin
                    time_d = time_dec;
                    if (time_dec == 16'd0) begin
                        state_d = ALARM;
                        acnt_d  = ALARM_CTR_WIDTH'(ALARM_TICKS);
                    end
                end
            end
            PAUSE: begin
                if (bus.btn_clear) begin
                    state_d = IDLE;
                    time_d  = 16'd0;
                end else if (bus.btn_start) begin
                    state_d     = RUN;
                    div_reset_d = 1'b1;
                end
            end
            ALARM: begin
                if (bus.btn_clear || bus.btn_start) begin
                    state_d = IDLE;
                    acnt_d  = '0;
                end else if (bus.tick) begin
                    acnt_d = acnt_q - 1'b1;
                    if (acnt_q <= ALARM_CTR_WIDTH'(1)) begin
                        state_d = IDLE;
                        acnt_d  = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            time_q      <= 16'd0;
            acnt_q      <= '0;
            div_reset_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            time_q      <= time_d;
            acnt_q      <= acnt_d;
            div_reset_q <= div_reset_d;
        end
    end

    assign bus.min_tens  = time_q[15:12];
    assign bus.min_ones  = time_q[11:8];
    assign bus.sec_tens  = time_q[7:4];
    assign bus.sec_ones  = time_q[3:0];
    assign bus.running   = (state_q == RUN);
    assign bus.alarm     = (state_q == ALARM);
    assign bus.div_reset = div_reset_q;

endmodule

// File: tb/tb_egg_timer_ctrl.sv
// Bench for egg_timer_ctrl: seconds-count reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_egg_timer_ctrl;
    localparam int AT = 10;
    localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_ALARM = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    bit   chk_en = 1'b0;
    int   checks = 0;
    int   errors = 0;

    egg_timer_ctrl_if bus();

    egg_timer_ctrl #(.ALARM_TICKS(AT), .ALARM_CTR_WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: time held as total seconds, state as plain integers.
    int m_t = 0, m_state = S_IDLE, m_acnt = 0;
    bit m_divr = 1'b0;
    int mm, ss;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_t = 0; m_state = S_IDLE; m_acnt = 0; m_divr = 1'b0;
        end else begin
            m_divr = 1'b0;
            if (bus.btn_clear) begin
                if (m_state != S_ALARM) m_t = 0;
                m_state = S_IDLE;
                m_acnt  = 0;
            end else if (bus.btn_start) begin
                case (m_state)
                    S_IDLE:  if (m_t != 0) begin m_state = S_RUN; m_divr = 1'b1; end
                    S_RUN:   m_state = S_PAUSE;
                    S_PAUSE: begin m_state = S_RUN; m_divr = 1'b1; end
                    default: begin m_state = S_IDLE; m_acnt = 0; end
                endcase
            end else if (m_state == S_RUN && bus.tick) begin
                m_t = m_t - 1;
                if (m_t == 0) begin m_state = S_ALARM; m_acnt = AT; end
            end else if (m_state == S_ALARM && bus.tick) begin
                m_acnt = m_acnt - 1;
                if (m_acnt == 0) m_state = S_IDLE;
            end else if (m_state == S_IDLE) begin
                mm = m_t / 60;
                ss = m_t % 60;
                if (bus.btn_min) mm = (mm + 1) % 100;
                if (bus.btn_sec) ss = (ss + 1) % 60;
                m_t = mm * 60 + ss;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && !reset) begin
            check("min_tens",  int'(bus.min_tens),  (m_t / 60) / 10);
            check("min_ones",  int'(bus.min_ones),  (m_t / 60) % 10);
            check("sec_tens",  int'(bus.sec_tens),  (m_t % 60) / 10);
            check("sec_ones",  int'(bus.sec_ones),  (m_t % 60) % 10);
            check("running",   int'(bus.running),   int'(m_state == S_RUN));
            check("alarm",     int'(bus.alarm),     int'(m_state == S_ALARM));
            check("div_reset", int'(bus.div_reset), int'(m_divr));
        end
    end

    task automatic cyc(input bit st, input bit mi, input bit se, input bit cl, input bit tk);
        bus.btn_start = st; bus.btn_min = mi; bus.btn_sec = se;
        bus.btn_clear = cl; bus.tick = tk;
        @(negedge clk);
        bus.btn_start = 0; bus.btn_min = 0; bus.btn_sec = 0;
        bus.btn_clear = 0; bus.tick = 0;
    endtask

    task automatic lit_time(input string name, input int mt, input int mo, input int st, input int so);
        check({name, ".mt"}, int'(bus.min_tens), mt);
        check({name, ".mo"}, int'(bus.min_ones), mo);
        check({name, ".st"}, int'(bus.sec_tens), st);
        check({name, ".so"}, int'(bus.sec_ones), so);
    endtask

    initial begin
        bus.btn_start = 0; bus.btn_min = 0; bus.btn_sec = 0;
        bus.btn_clear = 0; bus.tick = 0;
        repeat (2) @(negedge clk);
        lit_time("rst", 0, 0, 0, 0);
        check("rst.running", int'(bus.running), 0);
        check("rst.alarm", int'(bus.alarm), 0);
        check("rst.div_reset", int'(bus.div_reset), 0);
        reset = 1'b0;
        chk_en = 1'b1;

        // Start at 00:00 is ignored
        cyc(1, 0, 0, 0, 0);
        check("zero_start.running", int'(bus.running), 0);
        check("zero_start.div_reset", int'(bus.div_reset), 0);

        // 03:05 countdown to alarm
        repeat (3) cyc(0, 1, 0, 0, 0);
        repeat (5) cyc(0, 0, 1, 0, 0);
        cyc(1, 0, 0, 0, 0);
        lit_time("set305", 0, 3, 0, 5);
        check("set305.div_reset", int'(bus.div_reset), 1);
        check("set305.running", int'(bus.running), 1);
        cyc(0, 0, 0, 0, 0);
        check("set305.div_reset_drop", int'(bus.div_reset), 0);
        repeat (184) cyc(0, 0, 0, 0, 1);
        lit_time("t184", 0, 0, 0, 1);
        check("t184.alarm", int'(bus.alarm), 0);
        cyc(0, 0, 0, 0, 1);
        lit_time("t185", 0, 0, 0, 0);
        check("t185.alarm", int'(bus.alarm), 1);

        // Alarm lasts exactly AT ticks
        repeat (AT - 1) cyc(0, 0, 0, 0, 1);
        check("alarm9.alarm", int'(bus.alarm), 1);
        cyc(0, 0, 0, 0, 1);
        check("alarm10.alarm", int'(bus.alarm), 0);

        // Wraps: 00:59 + sec -> 00:00, 99:00 + min -> 00:00
        repeat (59) cyc(0, 0, 1, 0, 0);
        lit_time("s59", 0, 0, 5, 9);
        cyc(0, 0, 1, 0, 0);
        lit_time("swrap", 0, 0, 0, 0);
        repeat (99) cyc(0, 1, 0, 0, 0);
        lit_time("m99", 9, 9, 0, 0);
        cyc(0, 1, 0, 0, 0);
        lit_time("mwrap", 0, 0, 0, 0);

        // Simultaneous min+sec, then clear
        cyc(0, 1, 1, 0, 0);
        lit_time("minsec", 0, 1, 0, 1);
        cyc(0, 0, 0, 1, 0);
        lit_time("clr_idle", 0, 0, 0, 0);

        // 01:00 -> 00:59, then start+tick pauses without decrement
        cyc(0, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1);
        lit_time("dec100", 0, 0, 5, 9);
        cyc(1, 0, 0, 0, 1);
        lit_time("pause", 0, 0, 5, 9);
        check("pause.running", int'(bus.running), 0);
        cyc(0, 1, 1, 0, 1);
        cyc(0, 0, 0, 0, 1);
        lit_time("pause_hold", 0, 0, 5, 9);
        cyc(1, 0, 0, 0, 0);
        check("resume.div_reset", int'(bus.div_reset), 1);
        cyc(0, 1, 1, 0, 1);
        lit_time("run_ignore_btn", 0, 0, 5, 8);
        cyc(1, 0, 0, 1, 1);
        lit_time("clr_run", 0, 0, 0, 0);
        check("clr_run.running", int'(bus.running), 0);

        // Alarm cut short by clear after 3 ticks, then by start
        cyc(0, 0, 1, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1);
        check("alarm2.alarm", int'(bus.alarm), 1);
        repeat (3) cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 1, 0);
        check("alarm_clr.alarm", int'(bus.alarm), 0);
        cyc(0, 0, 1, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 1);
        check("alarm_start.alarm", int'(bus.alarm), 0);
        lit_time("alarm_start", 0, 0, 0, 0);

        // Asynchronous reset mid-RUN at 02:17 while div_reset is high
        repeat (2) cyc(0, 1, 0, 0, 0);
        repeat (17) cyc(0, 0, 1, 0, 0);
        cyc(1, 0, 0, 0, 0);
        check("pre_rst.div_reset", int'(bus.div_reset), 1);
        lit_time("pre_rst", 0, 2, 1, 7);
        reset = 1'b1;
        #1;
        lit_time("async_rst", 0, 0, 0, 0);
        check("async_rst.running", int'(bus.running), 0);
        check("async_rst.div_reset", int'(bus.div_reset), 0);
        @(negedge clk);
        reset = 1'b0;
        cyc(0, 1, 0, 0, 0);
        lit_time("post_rst", 0, 1, 0, 0);
        repeat (2) cyc(0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
